// File: rtl/grf_scoreboard_if.sv
// Bundle of the scoreboarded register file's issue, write-back and read-port signals.
// The master side drives issue/write-back/read addresses; the slave side is the register file.
interface grf_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              issue_en;
  logic [4:0]        issue_rw;
  logic              we;
  logic [4:0]        wb_rw;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1;
  logic              busy2;
  logic              err_ovf;
  logic              err_unf;

  modport master (
    output issue_en, issue_rw, we, wb_rw, wb_data, ra1, ra2,
    input  rd1, rd2, busy1, busy2, err_ovf, err_unf
  );

  modport slave (
    input  issue_en, issue_rw, we, wb_rw, wb_data, ra1, ra2,
    output rd1, rd2, busy1, busy2, err_ovf, err_unf
  );
endinterface

// File: rtl/grf_scoreboard.sv
// MIPS general register file with per-register pending-write counters, write-through
// read bypass and busy flags for the hazard unit. Register 0 has no storage.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  grf_scoreboard_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_regs    [1:31];
  logic [CNT_W-1:0]  r_cnt     [1:31];
  logic              r_err_ovf;
  logic              r_err_unf;

  logic [CNT_W-1:0]  w_cnt_nxt [1:31];
  logic              w_inc     [1:31];
  logic              w_dec     [1:31];
  logic              w_ovf;
  logic              w_unf;

  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_busy1, w_busy2;
  logic              w_hit1, w_hit2;
  logic [CNT_W-1:0]  w_cnt1, w_cnt2;

  // Counter next-state: a simultaneous issue and retire on one register cancel out.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_ovf = 1'b0;
    w_unf = 1'b0;
    for (int r = 1; r < 32; r++) begin
      w_inc[r]     = bus.issue_en && (bus.issue_rw == 5'(r));
      w_dec[r]     = bus.we && (bus.wb_rw == 5'(r));
      w_cnt_nxt[r] = r_cnt[r];
      if (w_inc[r] && !w_dec[r]) begin
        if (r_cnt[r] == CNT_MAX) w_ovf = 1'b1;
        else                     w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
      end else if (w_dec[r] && !w_inc[r]) begin
        if (r_cnt[r] == '0) w_unf = 1'b1;
        else                w_cnt_nxt[r] = r_cnt[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!reset) begin
      // NOTE: the data array is cleared on reset because architectural registers must read 0 afterwards.
      for (int r = 1; r < 32; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (bus.we && (bus.wb_rw != 5'd0)) r_regs[bus.wb_rw] <= bus.wb_data;
      for (int r = 1; r < 32; r++) r_cnt[r] <= w_cnt_nxt[r];
      if (w_ovf) r_err_ovf <= 1'b1;
      if (w_unf) r_err_unf <= 1'b1;
    end
  end

  // Read ports: a write-back in flight this cycle is forwarded and also retires one pending mark.
  always_comb begin
    w_rd1   = '0;
    w_rd2   = '0;
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    w_cnt1  = '0;
    w_cnt2  = '0;
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    if (bus.ra1 != 5'd0) begin
      w_hit1  = bus.we && (bus.wb_rw == bus.ra1);
      w_cnt1  = r_cnt[bus.ra1];
      w_rd1   = w_hit1 ? bus.wb_data : r_regs[bus.ra1];
      w_busy1 = (w_cnt1 != '0) && !((w_cnt1 == CNT_ONE) && w_hit1);
    end
    if (bus.ra2 != 5'd0) begin
      w_hit2  = bus.we && (bus.wb_rw == bus.ra2);
      w_cnt2  = r_cnt[bus.ra2];
      w_rd2   = w_hit2 ? bus.wb_data : r_regs[bus.ra2];
      w_busy2 = (w_cnt2 != '0) && !((w_cnt2 == CNT_ONE) && w_hit2);
    end
  end

  assign bus.rd1     = w_rd1;
  assign bus.rd2     = w_rd2;
  assign bus.busy1   = w_busy1;
  assign bus.busy2   = w_busy2;
  assign bus.err_ovf = r_err_ovf;
  assign bus.err_unf = r_err_unf;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: each step pushes its expected outputs to a queue,
// which is drained and compared at the following falling edge.
module tb_grf_scoreboard;

  localparam int DATA_W = 32;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic        busy1;
    logic [31:0] rd2;
    logic        busy2;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  grf_scoreboard_if #(.DATA_W(DATA_W)) bus ();

  grf_scoreboard #(.DATA_W(DATA_W), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] rd1, input logic b1,
                            input logic [31:0] rd2, input logic b2,
                            input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag; e.rd1 = rd1; e.busy1 = b1; e.rd2 = rd2; e.busy2 = b2;
    e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  // Compare pending expectations mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".rd1"},   bus.rd1,            e.rd1);
      check({e.tag, ".busy1"}, {31'd0, bus.busy1}, {31'd0, e.busy1});
      check({e.tag, ".rd2"},   bus.rd2,            e.rd2);
      check({e.tag, ".busy2"}, {31'd0, bus.busy2}, {31'd0, e.busy2});
      check({e.tag, ".ovf"},   {31'd0, bus.err_ovf}, {31'd0, e.ovf});
      check({e.tag, ".unf"},   {31'd0, bus.err_unf}, {31'd0, e.unf});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_en = 1'b0;
    bus.issue_rw = 5'd0;
    bus.we       = 1'b0;
    bus.wb_rw    = 5'd0;
    bus.wb_data  = '0;
  endtask

  task automatic drive_issue(input logic [4:0] rw);
    bus.issue_en = 1'b1;
    bus.issue_rw = rw;
  endtask

  task automatic drive_wb(input logic [4:0] rw, input logic [31:0] data);
    bus.we      = 1'b1;
    bus.wb_rw   = rw;
    bus.wb_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd0;

    // Reset, then read two untouched registers.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    bus.ra1 = 5'd5;
    bus.ra2 = 5'd31;
    expect_out("reset_read", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Issue to r8: not busy in the issue cycle, busy afterwards.
    bus.ra1 = 5'd8;
    bus.ra2 = 5'd0;
    drive_issue(5'd8);
    expect_out("issue_r8_same_cycle", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("r8_busy_c2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("r8_busy_c3", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Write-back to r8 forwards and clears busy combinationally on both ports.
    bus.ra2 = 5'd8;
    drive_wb(5'd8, 32'hDEADBEEF);
    expect_out("r8_wb_bypass", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("r8_stored", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    step();

    // Register 0: issue and write-back have no effect.
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd0;
    drive_issue(5'd0);
    expect_out("r0_issue", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    drive_wb(5'd0, 32'h00001234);
    expect_out("r0_wb", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("r0_after", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Three in-flight writes to r3 saturate the counter; a fourth sets err_ovf.
    bus.ra1 = 5'd3;
    drive_issue(5'd3);
    expect_out("r3_issue1", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("r3_issue2", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("r3_issue3", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("r3_issue4", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("r3_ovf_set", 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive_wb(5'd3, 32'h1);
    expect_out("r3_wb1", 32'h1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive_wb(5'd3, 32'h2);
    expect_out("r3_wb2", 32'h2, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive_wb(5'd3, 32'h3);
    expect_out("r3_wb3", 32'h3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    expect_out("r3_final", 32'h3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();

    // r9 at cnt=1: simultaneous issue and write-back keeps cnt at 1.
    bus.ra1 = 5'd0;
    bus.ra2 = 5'd9;
    drive_issue(5'd9);
    expect_out("r9_issue", 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive_issue(5'd9);
    drive_wb(5'd9, 32'h0000CAFE);
    expect_out("r9_inc_dec", 32'h0, 1'b0, 32'h0000CAFE, 1'b0, 1'b1, 1'b0);
    step();
    idle();
    expect_out("r9_still_busy", 32'h0, 1'b0, 32'h0000CAFE, 1'b1, 1'b1, 1'b0);
    step();

    // Underflow on r12: data still written, err_unf set next cycle, busy never wraps.
    bus.ra1 = 5'd12;
    drive_wb(5'd12, 32'h000055AA);
    expect_out("r12_unf_cycle", 32'h000055AA, 1'b0, 32'h0000CAFE, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    expect_out("r12_unf_set", 32'h000055AA, 1'b0, 32'h0000CAFE, 1'b1, 1'b1, 1'b1);
    step();

    // Reset dominates a same-cycle issue and discards all pending marks.
    reset = 1'b0;
    drive_issue(5'd12);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    expect_out("post_reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- General register file for the MIPS core, sitting directly downstream of the write-register select stage.
- Consumes the 5-bit destination register number that stage produces, at two points:
  - at issue, to mark the destination pending;
  - at write-back, to commit data and retire the pending mark.
- Provides two combinational read ports with write-through bypass, plus per-port busy flags that the hazard unit uses to stall.

Parameters:
- DATA_W, 32, register data width
- CNT_W, 2, width of per-register pending-write counter (max 2^CNT_W-1 in-flight writes per register)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- issue_en  input  1  an instruction with a destination register issues this cycle
- issue_rw  input  5  destination register number of issuing instruction (from write-register select)
- we  input  1  write-back enable
- wb_rw  input  5  write-back destination register number
- wb_data  input  DATA_W  write-back data
- ra1  input  5  read address, port 1 (rs)
- ra2  input  5  read address, port 2 (rt)
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2
- busy1  output  1  ra1 has an outstanding write not yet committed
- busy2  output  1  ra2 has an outstanding write not yet committed
- err_ovf  output  1  sticky: issue attempted on a saturated counter
- err_unf  output  1  sticky: write-back retired a register whose counter was 0

Behaviour:
- State:
  - regs[1..31], DATA_W each;
  - cnt[1..31], CNT_W each;
  - err_ovf, err_unf flags.
  - Register 0 has no storage: reads 0, never busy.
- Reset:
  - When reset==0 at a rising edge: all regs=0, all cnt=0, err_ovf=0, err_unf=0.
  - Reset dominates issue_en and we in the same cycle.
  - Reset mid-operation discards all pending marks.
- Register write:
  - If we && wb_rw!=0, regs[wb_rw] <= wb_data at the rising edge.
  - wb_rw==0: no storage change, no counter change, no error.
- Counter update, per register r!=0, each cycle; inc = issue_en && issue_rw==r, dec = we && wb_rw==r:
  - inc only: cnt<=cnt+1 if cnt<max. If cnt==max: cnt holds, err_ovf<=1.
  - dec only: cnt<=cnt-1 if cnt>0. If cnt==0: cnt holds at 0, err_unf<=1. Data is still written.
  - inc and dec: cnt unchanged, no error, even at 0 or max.
  - issue_rw==0 or issue_en==0: no effect.
- Errors are sticky until reset.
- Read ports, combinational, zero latency:
  - rdN = 0 if raN==0.
  - Else rdN = wb_data if we && wb_rw==raN (write-through bypass).
  - Else rdN = regs[raN].
- Busy, combinational:
  - busyN = 0 if raN==0.
  - Else busyN = (cnt[raN] - (we && wb_rw==raN ? 1 : 0)) != 0, computed without wrap: cnt==0 with write-back yields 0.
  - Same-cycle issue does not affect busy; it becomes visible next cycle.
- Timing: an issue at edge k sets busy from cycle k+1. A write-back in cycle m clears busy combinationally in cycle m if it retires the last pending write.
- Both read ports are fully independent and may address the same register.

Test Plan:
- Reset then reads: reset=0 one cycle, then ra1=5, ra2=31 -> rd1=rd2=0, busy1=busy2=0, err_ovf=err_unf=0.
- Issue/write-back round trip:
  - issue_en=1, issue_rw=8 at cycle 1 -> busy1=1 (ra1=8) from cycle 2.
  - Cycle 4: we=1, wb_rw=8, wb_data=0xDEADBEEF -> same cycle rd1=0xDEADBEEF, busy1=0.
  - Cycle 5: rd1=0xDEADBEEF from storage.
- Register 0:
  - issue_rw=0 then we=1, wb_rw=0, wb_data=0x1234 -> rd1(ra1=0)=0, busy1=0, no errors.
- Multiple in-flight:
  - Three issues to r3 -> cnt=3.
  - A fourth issue -> err_ovf=1, cnt stays 3.
  - Three write-backs 0x1,0x2,0x3 -> busy stays 1 until the third write-back cycle; final rd=0x3.
- Simultaneous issue and write-back to r9 with cnt=1 -> cnt stays 1, busy=1 next cycle, rd=written value.
- Underflow and reset priority:
  - we=1, wb_rw=12 with cnt=0 -> err_unf=1, regs[12] updated.
  - Then reset=0 with issue_en=1, issue_rw=12 -> cnt[12]=0, err_unf=0, regs[12]=0.
